// File: rtl/ddr2_refresh_ctrl_if.sv
// Refresh engine <-> arbiter / DDR2 command pin bundle.
// Bus widths come from the BA_BITS and ADDR_BITS macros (defaulted here when not given).
`ifndef BA_BITS
`define BA_BITS 3
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 14
`endif

interface ddr2_refresh_ctrl_if #(
  parameter int unsigned PEND_W = 4
);
  logic                    ref_req;
  logic                    ref_ack;
  logic                    ref_busy;
  logic                    ref_done;
  logic                    ref_err;
  logic [PEND_W-1:0]       pend_cnt;
  logic                    cmd_cke;
  logic                    cmd_cs_n;
  logic                    cmd_ras_n;
  logic                    cmd_cas_n;
  logic                    cmd_we_n;
  logic [`BA_BITS-1:0]     cmd_ba;
  logic [`ADDR_BITS-1:0]   cmd_addr;

  // Refresh engine side: owns the request and the command pins.
  modport master (
    output ref_req, ref_busy, ref_done, ref_err, pend_cnt,
    output cmd_cke, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_ba, cmd_addr,
    input  ref_ack
  );

  // Arbiter / PHY side.
  modport slave (
    input  ref_req, ref_busy, ref_done, ref_err, pend_cnt,
    input  cmd_cke, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_ba, cmd_addr,
    output ref_ack
  );
endinterface

// File: rtl/ddr2_refresh_ctrl.sv
// DDR2 auto-refresh engine: tREFI interval timer, postponed-refresh counter,
// bus request/grant, then PRECHARGE-ALL + AUTO REFRESH on registered command pins.
// Optional feature macro: REF_BURST_EN (drain pending refreshes back-to-back per grant).
`ifndef BA_BITS
`define BA_BITS 3
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 14
`endif

module ddr2_refresh_ctrl #(
  parameter int unsigned TREFI_CYC = 1560,
  parameter int unsigned TRP_CYC   = 3,
  parameter int unsigned TRFC_CYC  = 26,
  parameter int unsigned MAX_PEND  = 8
) (
  input  logic               ck,
  input  logic               rst_n,
  input  logic               init_done,
  ddr2_refresh_ctrl_if.master bus
);

  localparam int unsigned TMR_W   = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;
  localparam int unsigned PEND_W  = $clog2(MAX_PEND + 1);
  localparam int unsigned SPC_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int unsigned CNT_W   = $clog2(SPC_MAX + 1);
  localparam int unsigned BA_W    = `BA_BITS;
  localparam int unsigned ADDR_W  = `ADDR_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_PRE, S_WAIT_RP, S_AREF, S_WAIT_RFC, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              req_q, req_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              cke_q, cke_d, cs_n_q, cs_n_d, ras_n_q, ras_n_d;
  logic              cas_n_q, cas_n_d, we_n_q, we_n_d;
  logic [BA_W-1:0]   ba_q, ba_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tick, issue_aref;

  // Next-state: interval timer, pending count, sequencer and registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    err_d      = err_q;
    issue_aref = 1'b0;
    tick       = init_done && (tmr_q == TMR_W'(TREFI_CYC - 1));
    tmr_d      = tick ? '0 : tmr_q + TMR_W'(1);

    unique case (state_q)
      S_IDLE: if (pend_q != '0) state_d = S_REQ;
      S_REQ: begin
        if (bus.ref_ack) begin
          state_d = S_PRE;
          cnt_d   = CNT_W'(TRP_CYC - 1);
        end
      end
      S_PRE, S_WAIT_RP: begin
        if (cnt_q == '0) begin
          state_d    = S_AREF;
          cnt_d      = CNT_W'(TRFC_CYC - 1);
          issue_aref = 1'b1;
        end else begin
          state_d = S_WAIT_RP;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_AREF, S_WAIT_RFC: begin
        if (cnt_q == '0) begin
`ifdef REF_BURST_EN
          if (pend_q != '0) begin
            state_d    = S_AREF;
            cnt_d      = CNT_W'(TRFC_CYC - 1);
            issue_aref = 1'b1;
          end else begin
            state_d = S_DONE;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_WAIT_RFC;
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A tick and an AREF on the same edge cancel out.
    if (tick && (pend_q == PEND_W'(MAX_PEND))) err_d = 1'b1;
    if (tick && !issue_aref && (pend_q != PEND_W'(MAX_PEND))) pend_d = pend_q + PEND_W'(1);
    if (!tick && issue_aref) pend_d = pend_q - PEND_W'(1);

    // Losing init_done drops everything back to idle; the error flag survives.
    if (!init_done) begin
      state_d = S_IDLE;
      tmr_d   = '0;
      cnt_d   = '0;
      pend_d  = '0;
    end

    req_d   = (state_d == S_REQ);
    busy_d  = (state_d inside {S_PRE, S_WAIT_RP, S_AREF, S_WAIT_RFC, S_DONE});
    done_d  = (state_d == S_DONE);
    cke_d   = 1'b1;
    cs_n_d  = 1'b0;
    ras_n_d = 1'b1;
    cas_n_d = 1'b1;
    we_n_d  = 1'b1;
    ba_d    = '0;
    addr_d  = '0;
    if (state_d == S_PRE) begin
      ras_n_d    = 1'b0;
      we_n_d     = 1'b0;
      addr_d[10] = 1'b1;
    end else if (state_d == S_AREF) begin
      ras_n_d = 1'b0;
      cas_n_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cke_q   <= 1'b1;
      cs_n_q  <= 1'b0;
      ras_n_q <= 1'b1;
      cas_n_q <= 1'b1;
      we_n_q  <= 1'b1;
      ba_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cke_q   <= cke_d;
      cs_n_q  <= cs_n_d;
      ras_n_q <= ras_n_d;
      cas_n_q <= cas_n_d;
      we_n_q  <= we_n_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.ref_req   = req_q;
  assign bus.ref_busy  = busy_q;
  assign bus.ref_done  = done_q;
  assign bus.ref_err   = err_q;
  assign bus.pend_cnt  = pend_q;
  assign bus.cmd_cke   = cke_q;
  assign bus.cmd_cs_n  = cs_n_q;
  assign bus.cmd_ras_n = ras_n_q;
  assign bus.cmd_cas_n = cas_n_q;
  assign bus.cmd_we_n  = we_n_q;
  assign bus.cmd_ba    = ba_q;
  assign bus.cmd_addr  = addr_q;

endmodule
